led_sequencer: RTL and testbench

- Parametrised successor to the single-spinner bringup LED driver.
- Drives NUM_LEDS bringup/debug LED or extra/bodge pins from a shared prescaler.
- Selectable modes: off, rotate (spinner), blink, PWM breathe.
- Pattern is runtime-loadable, rotation direction and pause are controllable, and a tick strobe is exported for other bringup logic.

---
 rtl/led_sequencer.sv | 95 +++++++++
 tb/tb_led_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// Multi-mode bringup LED driver: off / rotating spinner / blink / PWM breathe,
// all paced by one shared prescaler whose tick is also exported.
module led_sequencer #(
   parameter int                  NUM_LEDS     = 8,
   parameter int                  PRESCALE     = 1200000,
   parameter logic [NUM_LEDS-1:0] INIT_PATTERN = 8'b00111011,
   parameter int                  PWM_BITS     = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          mode,
   input  logic                dir,
   input  logic                pause,
   input  logic                load_valid,
   input  logic [NUM_LEDS-1:0] load_data,
   output logic [NUM_LEDS-1:0] leds,
   output logic                tick
);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ROTATE  = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_t;

   localparam int                 CNT_W     = $clog2(PRESCALE);
   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

   logic [CNT_W-1:0]    prescale_cnt;
   logic [NUM_LEDS-1:0] pattern;
   logic                phase;
   logic                level_up;
   logic [PWM_BITS-1:0] level;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                tick_int;
   mode_t               mode_sel;

   assign mode_sel = mode_t'(mode);
   assign tick_int = (prescale_cnt == CNT_LAST) && !pause;

   // Triangle step: returns {next level_up, next level}, bouncing off both ends.
   function automatic logic [PWM_BITS:0] breathe_step(input logic [PWM_BITS-1:0] lvl,
                                                      input logic up);
      if (up) begin
         if (lvl == LEVEL_MAX) return {1'b0, LEVEL_MAX - 1'b1};
         return {1'b1, lvl + 1'b1};
      end
      if (lvl == '0) return {1'b1, PWM_BITS'(1)};
      return {1'b0, lvl - 1'b1};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         prescale_cnt <= '0;
         pattern      <= INIT_PATTERN;
         phase        <= 1'b0;
         level        <= '0;
         level_up     <= 1'b1;
         pwm_cnt      <= '0;
         leds         <= '0;
         tick         <= 1'b0;
      end else begin
         tick    <= tick_int;
         pwm_cnt <= pwm_cnt + 1'b1;

         if (!pause)
            prescale_cnt <= (prescale_cnt == CNT_LAST) ? '0 : prescale_cnt + 1'b1;

         // A load always beats a rotate landing on the same tick.
         if (load_valid)
            pattern <= load_data;
         else if (tick_int && mode_sel == MODE_ROTATE)
            pattern <= dir ? {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]}
                           : {pattern[0], pattern[NUM_LEDS-1:1]};

         if (tick_int && mode_sel == MODE_BLINK)
            phase <= !phase;

         if (tick_int && mode_sel == MODE_BREATHE)
            {level_up, level} <= breathe_step(level, level_up);

         // ---- output stage: leds reflect state as it stood before this edge ----
         unique case (mode_sel)
            MODE_OFF:     leds <= '0;
            MODE_ROTATE:  leds <= pattern;
            MODE_BLINK:   leds <= phase ? pattern : '0;
            MODE_BREATHE: leds <= pattern & {NUM_LEDS{pwm_cnt < level}};
            default:      leds <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed test-plan sequences plus random traffic,
// every cycle scored against a counting-based reference model.
module tb_led_sequencer;

   localparam int N      = 8;
   localparam int PRESC  = 4;
   localparam int PWM_B  = 2;
   localparam logic [7:0] INIT = 8'b00111011;

   logic         clk;
   logic         reset;
   logic [1:0]   mode;
   logic         dir;
   logic         pause;
   logic         load_valid;
   logic [N-1:0] load_data;
   logic [N-1:0] leds;
   logic         tick;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: counts of elapsed events since reset.
   int         m_active;
   int         m_pwm;
   int         m_blinks;
   int         m_breaths;
   logic [7:0] m_pat;
   logic [8:0] exp_q[$];

   led_sequencer #(
      .NUM_LEDS(N), .PRESCALE(PRESC), .INIT_PATTERN(INIT), .PWM_BITS(PWM_B)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .dir(dir), .pause(pause),
      .load_valid(load_valid), .load_data(load_data), .leds(leds), .tick(tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic int tri_level(input int s);
      int m;
      int pos;
      m   = (1 << PWM_B) - 1;
      pos = s % (2 * m);
      return (pos <= m) ? pos : 2 * m - pos;
   endfunction

   // One clock edge: update the model from the inputs seen at this edge and
   // queue the outputs the DUT must show after it.
   task automatic step();
      logic       tint;
      logic [7:0] el;
      int         lvl;
      @(posedge clk);
      if (reset) begin
         m_active = 0; m_pwm = 0; m_blinks = 0; m_breaths = 0; m_pat = INIT;
         exp_q.push_back(9'h000);
      end else begin
         tint = !pause && ((m_active % PRESC) == PRESC - 1);
         lvl  = tri_level(m_breaths);
         case (mode)
            2'd0:    el = 8'h00;
            2'd1:    el = m_pat;
            2'd2:    el = (m_blinks % 2 == 1) ? m_pat : 8'h00;
            default: el = ((m_pwm % (1 << PWM_B)) < lvl) ? m_pat : 8'h00;
         endcase
         exp_q.push_back({tint, el});
         if (!pause) m_active++;
         m_pwm++;
         if (load_valid) m_pat = load_data;
         else if (mode == 2'd1 && tint)
            m_pat = dir ? ((m_pat << 1) | (m_pat >> 7)) : ((m_pat >> 1) | (m_pat << 7));
         if (mode == 2'd2 && tint) m_blinks++;
         if (mode == 2'd3 && tint) m_breaths++;
      end
      #1;
      load_valid = 1'b0;
   endtask

   task automatic do_reset(input logic [1:0] md, input logic d);
      reset = 1'b1; mode = md; dir = d; pause = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Scoreboard monitor: compares every queued expectation away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         chk("sb_leds", leds, exp_q[0][7:0]);
         chk("sb_tick", tick, exp_q[0][8]);
         void'(exp_q.pop_front());
      end
   end

   initial begin
      int ticks;
      int on;
      int exp_lvl[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      reset = 1'b1; mode = 2'd1; dir = 1'b0; pause = 1'b0;
      load_valid = 1'b0; load_data = '0;

      // Reset / default rotate right
      do_reset(2'd1, 1'b0);
      chk("rst_leds", leds, 8'h00);
      chk("rst_tick", tick, 1'b0);
      step();
      chk("init_pattern", leds, 8'h3B);
      step(); step();
      step();
      chk("first_tick", tick, 1'b1);
      step();
      chk("rot_right_1", leds, 8'h9D);
      step(); step(); step();
      step();
      chk("rot_right_2", leds, 8'hCE);

      // Direction and load-vs-tick priority
      do_reset(2'd1, 1'b1);
      repeat (4) step();
      step();
      chk("rot_left", leds, 8'h76);
      step(); step();
      load_valid = 1'b1; load_data = 8'h01;
      step();
      step();
      chk("load_wins", leds, 8'h01);
      repeat (3) step();
      step();
      chk("rot_after_load", leds, 8'h02);

      // Pause at count 2
      step();
      pause = 1'b1;
      ticks = 0;
      repeat (10) begin
         step();
         if (tick) ticks++;
      end
      chk("pause_no_tick", ticks, 0);
      chk("pause_frozen", leds, 8'h02);
      pause = 1'b0;
      step();
      chk("resume_tick_early", tick, 1'b0);
      step();
      chk("resume_tick", tick, 1'b1);

      // Blink
      do_reset(2'd2, 1'b0);
      load_valid = 1'b1; load_data = 8'hA5;
      step();
      chk("blink_start", leds, 8'h00);
      repeat (3) step();
      chk("blink_off", leds, 8'h00);
      step();
      chk("blink_on", leds, 8'hA5);
      repeat (3) step();
      chk("blink_on_end", leds, 8'hA5);
      step();
      chk("blink_off2", leds, 8'h00);

      // Breathe: count lit cycles per 4-cycle PWM window
      do_reset(2'd3, 1'b0);
      load_valid = 1'b1; load_data = 8'hFF;
      for (int j = 0; j < 8; j++) begin
         on = 0;
         for (int k = 0; k < 4; k++) begin
            step();
            chk("breathe_value", (leds == 8'h00 || leds == 8'hFF), 1'b1);
            if (leds == 8'hFF) on++;
         end
         chk("breathe_duty", on, exp_lvl[j]);
      end

      // OFF keeps ticking, then reset mid-breathe at level 2 with a tick pending
      mode = 2'd0;
      ticks = 0;
      repeat (8) begin
         step();
         chk("off_leds", leds, 8'h00);
         if (tick) ticks++;
      end
      chk("off_ticks", ticks, 2);
      mode = 2'd3;
      repeat (3) step();
      reset = 1'b1;
      step();
      chk("midrst_leds", leds, 8'h00);
      chk("midrst_tick", tick, 1'b0);
      reset = 1'b0; mode = 2'd1;
      step();
      chk("midrst_pattern", leds, INIT);
      mode = 2'd3;
      repeat (3) begin
         step();
         chk("midrst_level0", leds, 8'h00);
      end

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0) dir = ~dir;
         pause      = ($urandom_range(0, 4) == 0);
         load_valid = ($urandom_range(0, 7) == 0);
         load_data  = 8'($urandom_range(0, 255));
         reset      = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_drain", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
